conv3x3_mac: RTL and testbench

- Downstream neighbour of the 3x3 line buffer; consumes its nine window pixels plus window-valid strobe.
- Applies a programmable signed 3x3 kernel: multiply-accumulate, rounding, right shift, clamp to an unsigned pixel.
- Emits one output pixel per valid window through a fixed-latency pipeline.
- Kernel coefficients are double-buffered (shadow/active) so reprogramming never corrupts a window in flight.

---
 rtl/conv3x3_mac.sv | 131 +++++++++++++
 tb/tb_conv3x3_mac.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac.sv
// Programmable signed 3x3 convolution: 3-stage multiply / row-sum / round-shift-clamp
// pipeline with a double-buffered (shadow/active) coefficient bank.
module conv3x3_mac #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     valid_in,
    input  logic [PIX_W-1:0]         w00,
    input  logic [PIX_W-1:0]         w01,
    input  logic [PIX_W-1:0]         w02,
    input  logic [PIX_W-1:0]         w10,
    input  logic [PIX_W-1:0]         w11,
    input  logic [PIX_W-1:0]         w12,
    input  logic [PIX_W-1:0]         w20,
    input  logic [PIX_W-1:0]         w21,
    input  logic [PIX_W-1:0]         w22,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    input  logic                     coef_commit,
    input  logic [3:0]               shift_amt,
    output logic [PIX_W-1:0]         px_out,
    output logic                     valid_out,
    output logic                     commit_pending,
    output logic [15:0]              sat_count
);

    localparam int ACC_W  = PIX_W + COEF_W + 5;
    localparam int PROD_W = PIX_W + 1 + COEF_W;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    logic [PIX_W-1:0]         pix     [0:8];
    logic signed [COEF_W-1:0] shadow  [0:8];
    logic signed [COEF_W-1:0] active  [0:8];
    logic signed [PROD_W-1:0] prod    [0:8];
    logic signed [PROD_W-1:0] prod_q  [0:8];
    logic signed [ACC_W-1:0]  row_q   [0:2];
    logic                     v1, v2;
    logic                     do_copy;

    logic signed [ACC_W-1:0]  sum, rnd, rounded, shifted;
    logic [PIX_W-1:0]         px_next;
    logic                     clamp;

    assign pix[0] = w00;
    assign pix[1] = w01;
    assign pix[2] = w02;
    assign pix[3] = w10;
    assign pix[4] = w11;
    assign pix[5] = w12;
    assign pix[6] = w20;
    assign pix[7] = w21;
    assign pix[8] = w22;

    // The active bank may only change when nothing is using it.
    assign do_copy = commit_pending && !valid_in && !v1 && !v2 && !valid_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 9; i++) begin
                shadow[i] <= (i == 4) ? COEF_W'(1) : '0;
                active[i] <= (i == 4) ? COEF_W'(1) : '0;
            end
            commit_pending <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the copy below read shadow as it was
            // before this edge, so a write landing on the copy edge stays in shadow only.
            if (coef_we && coef_addr <= 4'd8)
                shadow[coef_addr] <= coef_wdata;
            if (do_copy)
                for (int i = 0; i < 9; i++)
                    active[i] <= shadow[i];
            commit_pending <= do_copy ? 1'b0 : (commit_pending | coef_commit);
        end
    end

    always_comb begin
        for (int i = 0; i < 9; i++)
            prod[i] = PROD_W'($signed({1'b0, pix[i]})) * PROD_W'(active[i]);
    end

    // NOTE: datapath registers carry no reset; they are only consumed when their
    // stage valid is set, and the valids themselves are reset.
    always_ff @(posedge clk) begin
        if (valid_in)
            for (int i = 0; i < 9; i++)
                prod_q[i] <= prod[i];
        if (v1)
            for (int r = 0; r < 3; r++)
                row_q[r] <= ACC_W'(prod_q[3*r]) + ACC_W'(prod_q[3*r+1]) + ACC_W'(prod_q[3*r+2]);
    end

    // NOTE: every output of this block is assigned first so no latch is inferred.
    always_comb begin
        px_next = '0;
        clamp   = 1'b0;
        sum     = row_q[0] + row_q[1] + row_q[2];
        rnd     = (shift_amt != 4'd0) ? (ACC_W'(1) <<< (shift_amt - 4'd1)) : '0;
        rounded = sum + rnd;
        shifted = rounded >>> shift_amt;
        if (shifted[ACC_W-1]) begin
            clamp = 1'b1;
        end else if (shifted > PIX_MAX) begin
            px_next = '1;
            clamp   = 1'b1;
        end else begin
            px_next = shifted[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            valid_out <= 1'b0;
            px_out    <= '0;
            sat_count <= '0;
        end else begin
            v1        <= valid_in;
            v2        <= v1;
            valid_out <= v2;
            if (v2)
                px_out <= px_next;
            if (v2 && clamp && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Self-checking bench for conv3x3_mac: table-driven kernels plus hand sequences for
// deferred commit, write/commit collision and asynchronous reset mid-stream.
module tb_conv3x3_mac;

    typedef logic [8:0][7:0] win_t;
    typedef logic [8:0][7:0] kern_t;
    typedef struct {int kid; win_t w; int sh; int exp;} vec_t;
    typedef struct {int px; int due;} exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       valid_in = 1'b0;
    logic [7:0] w00 = '0, w01 = '0, w02 = '0, w10 = '0, w11 = '0, w12 = '0, w20 = '0, w21 = '0, w22 = '0;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic signed [7:0] coef_wdata = '0;
    logic       coef_commit = 1'b0;
    logic [3:0] shift_amt = '0;
    logic [7:0] px_out;
    logic       valid_out;
    logic       commit_pending;
    logic [15:0] sat_count;

    conv3x3_mac dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .w00(w00), .w01(w01), .w02(w02), .w10(w10), .w11(w11), .w12(w12),
        .w20(w20), .w21(w21), .w22(w22),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_commit(coef_commit), .shift_amt(shift_amt),
        .px_out(px_out), .valid_out(valid_out),
        .commit_pending(commit_pending), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   exp_sat = 0;
    exp_t q[$];
    vec_t tbl[$];
    kern_t tb_k;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output side of the scoreboard: every valid_out must match the oldest expectation.
    always @(negedge clk) begin
        if (rstn && valid_out) begin
            if (q.size() == 0) begin
                check("unexpected_valid_out", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("px_out", int'(px_out), e.px);
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    function automatic win_t centered(input int c, input int o);
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = 8'(o);
        w[4] = 8'(c);
        return w;
    endfunction

    function automatic win_t ramp();
        win_t w;
        for (int i = 0; i < 9; i++) w[i] = 8'(i * 10);
        return w;
    endfunction

    function automatic kern_t kern_of(input int kid);
        kern_t k;
        for (int i = 0; i < 9; i++)
            k[i] = (kid == 1) ? 8'sd1 : (kid == 2) ? -8'sd1 : 8'sd0;
        k[4] = (kid == 2) ? 8'sd8 : 8'sd1;
        return k;
    endfunction

    function automatic int ref_px(input win_t w, input kern_t k, input int sh, output bit sat);
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(w[i]) * int'($signed(k[i]));
        if (sh > 0) s += 1 << (sh - 1);
        s = s >>> sh;
        sat = (s < 0) || (s > 255);
        return (s < 0) ? 0 : (s > 255) ? 255 : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input win_t w);
        w00 = w[0]; w01 = w[1]; w02 = w[2];
        w10 = w[3]; w11 = w[4]; w12 = w[5];
        w20 = w[6]; w21 = w[7]; w22 = w[8];
    endtask

    task automatic drive(input win_t w, input int exp);
        tick();
        valid_in = 1'b1;
        coef_we = 1'b0;
        coef_commit = 1'b0;
        set_win(w);
        q.push_back('{exp, cyc + 3});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            valid_in = 1'b0;
            coef_we = 1'b0;
            coef_commit = 1'b0;
        end
    endtask

    task automatic wait_commit(input string name);
        int n = 0;
        while (commit_pending && n < 20) begin
            tick();
            coef_commit = 1'b0;
            n++;
        end
        check(name, int'(commit_pending), 0);
    endtask

    task automatic load_kernel(input kern_t k, input int sh);
        for (int i = 0; i < 9; i++) begin
            tick();
            valid_in = 1'b0;
            coef_we = 1'b1;
            coef_addr = 4'(i);
            coef_wdata = k[i];
        end
        tick();
        coef_we = 1'b0;
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        wait_commit("load_commit");
        shift_amt = 4'(sh);
        tb_k = k;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int cur_kid;
        bit s;
        win_t w;

        // kid 0 = identity (reset bank), 1 = box, 2 = Laplacian
        tbl.push_back('{0, centered(77, 0), 0, 77});
        tbl.push_back('{0, centered(200, 50), 0, 200});
        tbl.push_back('{0, centered(0, 255), 0, 0});
        tbl.push_back('{0, centered(255, 255), 0, 255});
        for (int i = 0; i < 10; i++) tbl.push_back('{1, centered(100, 100), 3, 113});
        tbl.push_back('{1, ramp(), 3, 45});
        tbl.push_back('{1, centered(1, 1), 3, 1});
        tbl.push_back('{1, centered(4, 4), 3, 5});
        tbl.push_back('{2, centered(255, 0), 0, 255});
        tbl.push_back('{2, centered(0, 255), 0, 0});
        tbl.push_back('{2, centered(10, 2), 0, 64});
        tbl.push_back('{2, centered(100, 100), 0, 0});
        tbl.push_back('{2, centered(32, 1), 0, 248});

        tb_k = kern_of(0);
        #3;
        check("reset_px_out", int'(px_out), 0);
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_commit_pending", int'(commit_pending), 0);
        check("reset_sat_count", int'(sat_count), 0);
        #9 rstn = 1'b1;

        cur_kid = 0;
        foreach (tbl[i]) begin
            if (tbl[i].kid != cur_kid) begin
                load_kernel(kern_of(tbl[i].kid), tbl[i].sh);
                cur_kid = tbl[i].kid;
            end
            drive(tbl[i].w, tbl[i].exp);
        end
        idle(6);
        check("sat_count_after_table", int'(sat_count), 2);
        exp_sat = 2;

        // Deferred commit: reprogram to box and commit while a stream is running.
        for (int i = 0; i < 12; i++) begin
            tick();
            valid_in = 1'b1;
            for (int j = 0; j < 9; j++) w[j] = 8'($urandom);
            set_win(w);
            q.push_back('{ref_px(w, tb_k, 0, s), cyc + 3});
            if (s) exp_sat++;
            coef_we = (i >= 1 && i <= 9);
            coef_addr = 4'(i - 1);
            coef_wdata = 8'sd1;
            coef_commit = (i == 10);
            if (i == 11) check("pending_during_stream", int'(commit_pending), 1);
        end
        tick();
        valid_in = 1'b0;
        check("pending_while_draining", int'(commit_pending), 1);
        wait_commit("deferred_commit");
        tb_k = kern_of(1);
        drive(centered(10, 10), 90);
        idle(6);
        check("sat_count_after_stream", int'(sat_count), exp_sat);
        shift_amt = 4'd3;

        // Illegal address must not touch any coefficient.
        tick();
        coef_we = 1'b1; coef_addr = 4'd12; coef_wdata = 8'sd99;
        tick();
        coef_we = 1'b0; coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        wait_commit("illegal_addr_commit");
        drive(ramp(), 45);
        idle(5);

        // Write on the copy edge: active takes the pre-write shadow value.
        tick();
        coef_we = 1'b1; coef_addr = 4'd4; coef_wdata = 8'sd2;
        tick();
        coef_we = 1'b0; coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        coef_we = 1'b1; coef_addr = 4'd4; coef_wdata = 8'sd5;
        tick();
        coef_we = 1'b0;
        check("copy_edge_pending", int'(commit_pending), 0);
        drive(centered(100, 100), 125);
        idle(1);
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        wait_commit("second_commit");
        drive(centered(100, 100), 163);
        idle(6);

        // Asynchronous reset with two windows in flight.
        drive(centered(100, 100), 163);
        drive(centered(100, 100), 163);
        tick();
        valid_in = 1'b0;
        #2 rstn = 1'b0;
        q.delete();
        #1;
        check("midreset_valid_out", int'(valid_out), 0);
        check("midreset_px_out", int'(px_out), 0);
        check("midreset_sat_count", int'(sat_count), 0);
        #3 rstn = 1'b1;
        shift_amt = 4'd0;
        tb_k = kern_of(0);
        idle(6);
        drive(centered(77, 50), 77);
        idle(6);
        check("scoreboard_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
